// File: rtl/swgbe_oflow_monitor_pkg.sv
// Shared types and constants for the 10GbE overflow monitor.
package swgbe_mon_pkg;

  // Frame-tracking FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IN_FRAME = 2'd1,
    DROP     = 2'd2
  } mon_state_e;

  // Status word bit positions (OFLOW_LSB is the default-width counter LSB)
  localparam int OFLOW_LSB     = 16;
  localparam int BAD_LSB       = 4;
  localparam int AFULL_BIT     = 3;
  localparam int STK_AFULL_BIT = 2;
  localparam int STK_OFLOW_BIT = 1;
  localparam int DROP_BIT      = 0;

  localparam int STATUS_W      = 32;
  localparam int CNT_TOTAL_W   = 28;

endpackage

// File: rtl/swgbe_oflow_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear first, then increment unless already pinned at max
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/swgbe_oflow_monitor.sv
// 10GbE transmit overflow monitor: tracks frame boundaries, drops the rest
// of a frame after a core overflow, and publishes a 32-bit status word.
module swgbe_oflow_monitor
  import swgbe_mon_pkg::*;
#(
  parameter int OFLOW_CNT_W = 16,
  parameter int BAD_CNT_W   = 12
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic                tx_valid,
  input  logic                tx_eof,
  input  logic                tx_overflow,
  input  logic                tx_afull,
  input  logic                sw_clr,
  output logic                tx_drop,
  output logic [STATUS_W-1:0] status_word
);

  // Both counters plus the four flag bits must fill the 32-bit word exactly
  if (OFLOW_CNT_W + BAD_CNT_W != CNT_TOTAL_W) begin : g_width_check
    $error("swgbe_oflow_monitor: OFLOW_CNT_W + BAD_CNT_W must equal 28");
  end

  mon_state_e state_q, state_d;
  logic       drop_q, drop_d;
  logic       afull_q, afull_d;
  logic       sticky_oflow_q, sticky_oflow_d;
  logic       sticky_afull_q, sticky_afull_d;
  logic       sw_clr_dly_q, sw_clr_dly_d;

  logic       clr_pulse_s;
  logic       bad_inc_s;
  logic       v_s, e_s, o_s;

  logic [OFLOW_CNT_W-1:0] oflow_cnt_s;
  logic [BAD_CNT_W-1:0]   bad_cnt_s;
  logic [STATUS_W-1:0]    status_s;

  assign v_s = tx_valid;
  assign e_s = tx_eof;
  assign o_s = tx_overflow;

  // Software clear fires once per rising edge of the control level
  assign clr_pulse_s  = sw_clr & ~sw_clr_dly_q;
  assign sw_clr_dly_d = sw_clr;

  // FSM state register
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and bad-frame event
  always_comb begin
    state_d   = state_q;
    bad_inc_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (v_s && !e_s && !o_s) begin
          state_d = IN_FRAME;
        end else if (v_s && !e_s && o_s) begin
          state_d = DROP;
        end else if (v_s && e_s && o_s) begin
          // single-word frame rejected by the core
          bad_inc_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      IN_FRAME: begin
        if (v_s && e_s) begin
          state_d   = IDLE;
          bad_inc_s = o_s;
        end else if (o_s) begin
          // overflow counts even without a valid word
          state_d = DROP;
        end else begin
          state_d = IN_FRAME;
        end
      end
      DROP: begin
        if (v_s && e_s) begin
          state_d   = IDLE;
          bad_inc_s = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM output: drop flag tracks the next state so it is a clean flop
  always_comb begin
    drop_d = 1'b0;
    if (state_d == DROP) begin
      drop_d = 1'b1;
    end else begin
      drop_d = 1'b0;
    end
  end

  // Sticky flags and afull sample; clear wins over a coincident set
  always_comb begin
    afull_d        = tx_afull;
    sticky_oflow_d = sticky_oflow_q;
    sticky_afull_d = sticky_afull_q;
    if (clr_pulse_s) begin
      sticky_oflow_d = 1'b0;
      sticky_afull_d = 1'b0;
    end else begin
      sticky_oflow_d = sticky_oflow_q | o_s;
      sticky_afull_d = sticky_afull_q | tx_afull;
    end
  end

  // Flag, drop and clear-edge registers
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      drop_q         <= 1'b0;
      afull_q        <= 1'b0;
      sticky_oflow_q <= 1'b0;
      sticky_afull_q <= 1'b0;
      sw_clr_dly_q   <= 1'b0;
    end else begin
      drop_q         <= drop_d;
      afull_q        <= afull_d;
      sticky_oflow_q <= sticky_oflow_d;
      sticky_afull_q <= sticky_afull_d;
      sw_clr_dly_q   <= sw_clr_dly_d;
    end
  end

  sat_counter #(.W(OFLOW_CNT_W)) u_oflow_cnt (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .inc   (o_s),
    .clr   (clr_pulse_s),
    .cnt   (oflow_cnt_s)
  );

  sat_counter #(.W(BAD_CNT_W)) u_bad_cnt (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .inc   (bad_inc_s),
    .clr   (clr_pulse_s),
    .cnt   (bad_cnt_s)
  );

  // Status word is a pure concatenation of registers
  always_comb begin
    status_s = {STATUS_W{1'b0}};
    status_s[BAD_LSB + BAD_CNT_W +: OFLOW_CNT_W] = oflow_cnt_s;
    status_s[BAD_LSB +: BAD_CNT_W]               = bad_cnt_s;
    status_s[AFULL_BIT]                          = afull_q;
    status_s[STK_AFULL_BIT]                      = sticky_afull_q;
    status_s[STK_OFLOW_BIT]                      = sticky_oflow_q;
    status_s[DROP_BIT]                           = drop_q;
  end

  assign status_word = status_s;
  assign tx_drop     = drop_q;

endmodule
